// File: rtl/wb_test_monitor_pkg.sv
// rtl/wb_test_monitor_pkg.sv - shared state encoding and width helpers for the writeback test monitor
package wb_test_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_CHECK,
      ST_DONE,
      ST_FAIL,
      ST_TMO
   } state_t;

   // Index width for n items, never narrower than one bit
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // States in which the monitor is not running: table writes and start are honoured here
   function automatic logic is_quiescent(input state_t s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAIL) || (s == ST_TMO);
   endfunction

endpackage

// File: rtl/wb_shadow_regfile.sv
// rtl/wb_shadow_regfile.sv - shadow copy of the CPU register file, one write port, one async read port
module wb_shadow_regfile
   import wb_test_monitor_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   localparam int RW      = clog2_min1(NUM_REGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [RW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [RW-1:0]   raddr,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata = (raddr == '0) ? '0 : regs[raddr];

endmodule

// File: rtl/wb_test_monitor.sv
// rtl/wb_test_monitor.sv - snoops CPU writeback, runs table-driven register checks on each test-flag write
module wb_test_monitor
   import wb_test_monitor_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int NUM_REGS       = 32,
   parameter int FLAG_REG       = 20,
   parameter int FINAL_TEST     = 42,
   parameter int TBL_DEPTH      = 64,
   parameter int TEST_W         = 11,
   parameter int TIMEOUT_CYCLES = 100000,
   localparam int RW            = clog2_min1(NUM_REGS),
   localparam int AW            = clog2_min1(TBL_DEPTH),
   localparam int CW            = AW + 1,
   localparam int TW            = clog2_min1(TIMEOUT_CYCLES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              wb_en,
   input  logic [RW-1:0]     wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              tbl_we,
   input  logic [AW-1:0]     tbl_addr,
   input  logic [TEST_W-1:0] tbl_test,
   input  logic [RW-1:0]     tbl_reg,
   input  logic [XLEN-1:0]   tbl_mask,
   input  logic [XLEN-1:0]   tbl_exp,
   input  logic [CW-1:0]     tbl_count,
   output logic              cpu_stall,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [TEST_W-1:0] cur_test,
   output logic [CW-1:0]     pass_count,
   output logic [TEST_W-1:0] fail_test,
   output logic [RW-1:0]     fail_reg,
   output logic [XLEN-1:0]   fail_got,
   output logic [XLEN-1:0]   fail_exp
);

   typedef struct packed {
      logic [TEST_W-1:0] test;
      logic [RW-1:0]     rg;
      logic [XLEN-1:0]   mask;
      logic [XLEN-1:0]   exp;
   } entry_t;

   state_t            state;
   entry_t            tbl [TBL_DEPTH];
   entry_t            ent;
   logic [TEST_W-1:0] nx_test;
   logic [CW-1:0]     ptr, ptr_nx, count;
   logic [TW-1:0]     timer;
   logic [TEST_W-1:0] flag_val;
   logic [XLEN-1:0]   sh_rdata;
   logic              accept, accept_chk, entry_ok, last_nx;

   always_ff @(posedge clk) begin
      if (tbl_we && is_quiescent(state)) tbl[tbl_addr] <= {tbl_test, tbl_reg, tbl_mask, tbl_exp};
   end

   assign ptr_nx  = ptr + 1'b1;
   assign ent     = tbl[ptr[AW-1:0]];
   assign nx_test = tbl[ptr_nx[AW-1:0]].test;

   wb_shadow_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_shadow (
      .clk   (clk),
      .rst   (rst),
      .we    (wb_en && (state != ST_CHECK)),
      .waddr (wb_rd),
      .wdata (wb_data),
      .raddr (ent.rg),
      .rdata (sh_rdata)
   );

   assign flag_val   = wb_data[TEST_W-1:0];
   assign accept     = rst && (state == ST_WAIT) && wb_en && (wb_rd == RW'(FLAG_REG)) && (flag_val > cur_test);
   assign accept_chk = accept && (flag_val != TEST_W'(FINAL_TEST));
   assign cpu_stall  = rst && ((state == ST_CHECK) || accept_chk);

   assign entry_ok = (sh_rdata & ent.mask) == (ent.exp & ent.mask);
   // Look one entry ahead so the final check of a test also returns to WAIT in the same cycle
   assign last_nx  = (ptr_nx == count) || (nx_test > cur_test);

   assign busy    = (state == ST_WAIT) || (state == ST_CHECK);
   assign done    = (state == ST_DONE) || (state == ST_FAIL) || (state == ST_TMO);
   assign pass    = (state == ST_DONE);
   assign fail    = (state == ST_FAIL);
   assign timeout = (state == ST_TMO);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         count      <= '0;
         timer      <= '0;
         cur_test   <= '0;
         pass_count <= '0;
         fail_test  <= '0;
         fail_reg   <= '0;
         fail_got   <= '0;
         fail_exp   <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_FAIL, ST_TMO: begin
               if (start) begin
                  state      <= ST_WAIT;
                  ptr        <= '0;
                  count      <= tbl_count;
                  timer      <= '0;
                  cur_test   <= '0;
                  pass_count <= '0;
                  fail_test  <= '0;
                  fail_reg   <= '0;
                  fail_got   <= '0;
                  fail_exp   <= '0;
               end
            end
            ST_WAIT: begin
               if (accept) begin
                  cur_test <= flag_val;
                  timer    <= '0;
                  state    <= accept_chk ? ST_CHECK : ST_DONE;
               end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  state <= ST_TMO;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_CHECK: begin
               if ((ptr == count) || (ent.test > cur_test)) begin
                  state <= ST_WAIT;
               end else if (ent.test < cur_test) begin
                  ptr <= ptr_nx;
                  if (last_nx) state <= ST_WAIT;
               end else if (entry_ok) begin
                  pass_count <= pass_count + 1'b1;
                  ptr        <= ptr_nx;
                  if (last_nx) state <= ST_WAIT;
               end else begin
                  state     <= ST_FAIL;
                  fail_test <= cur_test;
                  fail_reg  <= ent.rg;
                  fail_got  <= sh_rdata;
                  fail_exp  <= ent.exp;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_test_monitor.sv
// tb/tb_wb_test_monitor.sv - directed and randomized bench for wb_test_monitor against a test-level model
module tb_wb_test_monitor;

   localparam int FLAG  = 20;
   localparam int FINAL = 42;
   localparam int M_IDLE = 0, M_WAIT = 1, M_DONE = 2, M_FAIL = 3, M_TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        tbl_we = 1'b0;
   logic [5:0]  tbl_addr = '0;
   logic [10:0] tbl_test = '0;
   logic [4:0]  tbl_reg = '0;
   logic [31:0] tbl_mask = '0;
   logic [31:0] tbl_exp = '0;
   logic [6:0]  tbl_count = '0;
   logic        cpu_stall, busy, done, pass, fail, timeout;
   logic [10:0] cur_test, fail_test;
   logic [6:0]  pass_count;
   logic [4:0]  fail_reg;
   logic [31:0] fail_got, fail_exp;

   wb_test_monitor #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_test(tbl_test), .tbl_reg(tbl_reg),
      .tbl_mask(tbl_mask), .tbl_exp(tbl_exp), .tbl_count(tbl_count),
      .cpu_stall(cpu_stall), .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .cur_test(cur_test), .pass_count(pass_count),
      .fail_test(fail_test), .fail_reg(fail_reg), .fail_got(fail_got), .fail_exp(fail_exp)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_sh [32];
   logic [10:0] m_test [64];
   logic [4:0]  m_reg [64];
   logic [31:0] m_mask [64];
   logic [31:0] m_exp [64];
   int          m_state, m_ptr, m_count, m_pass;
   logic [10:0] m_cur, m_ft;
   logic [4:0]  m_fr;
   logic [31:0] m_fg, m_fe;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_sh[i] = '0;
      m_state = M_IDLE; m_ptr = 0; m_count = 0; m_pass = 0;
      m_cur = '0; m_ft = '0; m_fr = '0; m_fg = '0; m_fe = '0;
   endtask

   function automatic logic [4:0] m_status();
      case (m_state)
         M_WAIT:  return 5'b10000;
         M_DONE:  return 5'b01100;
         M_FAIL:  return 5'b01010;
         M_TMO:   return 5'b01001;
         default: return 5'b00000;
      endcase
   endfunction

   // Runs every table entry for the current test at once; returns expected stall cycles
   function automatic int model_check();
      int k = 0;
      while (m_ptr < m_count && m_test[m_ptr] <= m_cur) begin
         if (m_test[m_ptr] == m_cur) begin
            if ((m_sh[m_reg[m_ptr]] & m_mask[m_ptr]) != (m_exp[m_ptr] & m_mask[m_ptr])) begin
               m_state = M_FAIL;
               m_ft = m_cur; m_fr = m_reg[m_ptr]; m_fg = m_sh[m_reg[m_ptr]]; m_fe = m_exp[m_ptr];
               return k + 2;
            end
            m_pass++;
         end
         m_ptr++;
         k++;
      end
      m_state = M_WAIT;
      return 1 + ((k == 0) ? 1 : k);
   endfunction

   task automatic check_state(input string tag);
      chk({tag, "/status"}, {busy, done, pass, fail, timeout}, m_status());
      chk({tag, "/cur_test"}, cur_test, m_cur);
      chk({tag, "/pass_count"}, pass_count, 7'(m_pass));
      chk({tag, "/fail_id"}, {fail_test, fail_reg}, {m_ft, m_fr});
      chk({tag, "/fail_got"}, fail_got, m_fg);
      chk({tag, "/fail_exp"}, fail_exp, m_fe);
   endtask

   task automatic tbl_write(input int addr, input int t, input logic [4:0] r,
                            input logic [31:0] mk, input logic [31:0] e);
      tbl_we = 1'b1; tbl_addr = 6'(addr); tbl_test = 11'(t); tbl_reg = r; tbl_mask = mk; tbl_exp = e;
      @(posedge clk); #1;
      tbl_we = 1'b0;
      if (m_state != M_WAIT) begin
         m_test[addr] = 11'(t); m_reg[addr] = r; m_mask[addr] = mk; m_exp[addr] = e;
      end
   endtask

   task automatic do_start(input string tag, input int cnt);
      start = 1'b1; tbl_count = 7'(cnt);
      @(posedge clk); #1;
      start = 1'b0;
      if (m_state != M_WAIT) begin
         m_state = M_WAIT; m_ptr = 0; m_pass = 0; m_count = cnt;
         m_cur = '0; m_ft = '0; m_fr = '0; m_fg = '0; m_fe = '0;
      end
      check_state(tag);
   endtask

   // One writeback from the CPU, which then honours cpu_stall until it drops
   task automatic wb(input string tag, input logic [4:0] rd, input logic [31:0] data);
      logic [10:0] v;
      bit          acc;
      int          n, exp_n;
      v   = data[10:0];
      acc = (m_state == M_WAIT) && (rd == FLAG) && (v > m_cur);
      wb_en = 1'b1; wb_rd = rd; wb_data = data;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cpu_stall !== 1'b1) break;
         n++;
         @(posedge clk); #1;
         wb_en = 1'b0;
      end
      @(posedge clk); #1;
      wb_en = 1'b0;
      if (rd != 0) m_sh[rd] = data;
      exp_n = 0;
      if (acc) begin
         m_cur = v;
         if (v == FINAL) m_state = M_DONE;
         else exp_n = model_check();
      end
      chk({tag, "/stall_cycles"}, n, exp_n);
      check_state(tag);
   endtask

   initial begin
      logic [4:0]  r [3];
      logic [31:0] d [3];
      logic [4:0]  rr;
      logic [31:0] vv, mk, ee, tmp;
      int          n, ne, sel, cyc;

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset/cpu_stall", cpu_stall, 0);
      check_state("reset");
      rst = 1'b1;

      // Single full-mask entry passes, stall is accept cycle plus one check
      tbl_write(0, 1, 5'd10, 32'hFFFF_FFFF, 32'h0000_00DD);
      do_start("t1_start", 1);
      tbl_write(0, 1, 5'd10, 32'hFFFF_FFFF, 32'h0000_0000);
      wb("t1_x10", 5'd10, 32'h0000_00DD);
      wb("t1_flag", 5'd20, 32'd1);
      chk("t1_pass_count", pass_count, 7'd1);
      wb("t1_final", 5'd20, 32'd42);

      // Same entry, wrong value: first-failure capture, then cleared by start
      do_start("t2_start", 1);
      wb("t2_x10", 5'd10, 32'h0000_00DC);
      wb("t2_flag", 5'd20, 32'd1);
      chk("t2_fail_got", fail_got, 32'h0000_00DC);
      do_start("t2_restart", 1);
      wb("t2_final", 5'd20, 32'd42);

      // Partial mask: byte 1 compared only
      tbl_write(0, 7, 5'd13, 32'h0000_FF00, 32'h0000_CC00);
      tbl_write(1, 9, 5'd13, 32'h0000_FF00, 32'h0000_CD00);
      do_start("t3_start", 2);
      wb("t3_x13", 5'd13, 32'hAABB_CCDD);
      wb("t3_flag7", 5'd20, 32'd7);
      wb("t3_flag9", 5'd20, 32'd9);

      // Stale and repeated flags are ignored; upper data bits do not form part of the flag
      do_start("t4_start", 0);
      wb("t4_flag2", 5'd20, 32'd2);
      wb("t4_rep2", 5'd20, 32'd2);
      wb("t4_low1", 5'd20, 32'd1);
      chk("t4_cur_test", cur_test, 11'd2);
      wb("t4_hi3", 5'd20, 32'hABC0_0003);
      wb("t4_final", 5'd20, 32'd42);

      // No flag after start: timeout after exactly TIMEOUT_CYCLES cycles
      do_start("t5_start", 0);
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (timeout === 1'b1) break;
         cyc++;
         @(posedge clk); #1;
      end
      chk("t5_timeout_cycles", cyc, 16);
      @(posedge clk); #1;
      m_state = M_TMO;
      check_state("t5_tmo");

      for (int rnd = 0; rnd < 30; rnd++) begin
         for (int k = 0; k < 3; k++) begin
            r[k] = 5'($urandom_range(1, 19));
            d[k] = $urandom;
         end
         n = 0;
         for (int t = 1; t <= 4; t++) begin
            ne = $urandom_range(0, 2);
            for (int j = 0; j < ne; j++) begin
               sel = $urandom_range(0, 3);
               rr  = (sel == 3) ? 5'd0 : r[sel];
               vv  = (sel == 3) ? 32'd0 : d[sel];
               case ($urandom_range(0, 3))
                  0:       mk = 32'hFFFF_FFFF;
                  1:       mk = 32'h0000_FFFF;
                  2:       mk = 32'h0000_0000;
                  default: mk = $urandom;
               endcase
               ee = (vv & mk) | ($urandom & ~mk);
               if ($urandom_range(0, 5) == 0) ee = ee ^ (32'h1 << $urandom_range(0, 31));
               tbl_write(n, t, rr, mk, ee);
               n++;
            end
         end
         do_start("rnd_start", n);
         for (int k = 0; k < 3; k++) wb("rnd_reg", r[k], d[k]);
         for (int t = 1; t <= 4; t++) begin
            if (m_state != M_WAIT) break;
            if ($urandom_range(0, 3) == 0) continue;
            if ($urandom_range(0, 1) == 1) wb("rnd_fill", 5'($urandom_range(21, 31)), $urandom);
            if ($urandom_range(0, 2) == 0) begin
               tmp = $urandom;
               tmp[10:0] = m_cur;
               wb("rnd_stale", 5'd20, tmp);
            end
            tmp = $urandom;
            tmp[10:0] = 11'(t);
            wb("rnd_flag", 5'd20, tmp);
         end
         if (m_state == M_WAIT) wb("rnd_final", 5'd20, 32'd42);
      end

      // Reset one cycle into a three-entry check drops the stall immediately
      tbl_write(0, 5, 5'd0, 32'h0, 32'h0);
      tbl_write(1, 5, 5'd0, 32'h0, 32'h0);
      tbl_write(2, 5, 5'd0, 32'h0, 32'h0);
      do_start("t7_start", 3);
      wb_en = 1'b1; wb_rd = 5'd20; wb_data = 32'd5;
      @(negedge clk);
      chk("t7_accept_stall", cpu_stall, 1);
      @(posedge clk); #1;
      wb_en = 1'b0;
      @(negedge clk);
      chk("t7_check_stall", cpu_stall, 1);
      rst = 1'b0;
      #1;
      chk("t7_reset_stall", cpu_stall, 0);
      @(posedge clk); #1;
      model_reset();
      chk("t7_after_stall", cpu_stall, 0);
      check_state("t7_after");
      rst = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
